jtcop_obj_dma: RTL and testbench

JTCOP_OBJ_DMA -- requirements
Module: jtcop_obj_dma

---
 rtl/jtcop_obj_dma.sv | 145 ++++++++++++++
 tb/tb_jtcop_obj_dma.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_obj_dma.sv
// Object table DMA: CPU-written staging RAM copied into a double-buffered display RAM, banks swap on completion.
// Latency: obj_dout/vid_data 1 cycle; a copy takes DEPTH+2 cycles with dma_cen held high.
// Backpressure: dma_cen=0 stalls the copy in place; requests arriving while busy are merged into one pending copy.
module jtcop_obj_dma #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_dout,
    input  logic [DW/8-1:0] cpu_dsn,
    input  logic          cpu_rnw,
    input  logic          objram_cs,
    output logic [DW-1:0] obj_dout,
    input  logic          obj_copy,
    input  logic          dma_cen,
    output logic          dma_busy,
    output logic          dma_done,
    output logic          active_bank,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data
);
    localparam int BL    = DW / 8;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, COPY, FLUSH, SWAP} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] rd_addr, rd_addr_nxt;
    logic [AW-1:0] wr_addr;
    logic          pending, pending_nxt;
    logic          obj_copy_q;
    logic          armed;
    logic          req;
    logic          rd_issue;
    logic          wr_en;
    logic          swap;

    logic [DW-1:0] stg_mem [DEPTH];
    logic [DW-1:0] bank0   [DEPTH];
    logic [DW-1:0] bank1   [DEPTH];
    logic [DW-1:0] stg_rd_dat;

    // armed stays low for the first edge after reset so a level held high across release is not seen as a rise
    assign req = obj_copy & ~obj_copy_q & armed;

    assign dma_busy = (state != IDLE);
    assign dma_done = (state == SWAP);

    // The write of word n trails its read by one paced cycle, so the write address is always rd_addr-1
    // (this also lands on DEPTH-1 in FLUSH, after rd_addr has wrapped to 0).
    assign wr_addr = rd_addr - 1'b1;

    // Next-state logic for the copy sequencer
    always_comb begin
        state_nxt   = state;
        rd_addr_nxt = rd_addr;
        pending_nxt = pending;
        rd_issue    = 1'b0;
        wr_en       = 1'b0;
        swap        = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt   = COPY;
                    rd_addr_nxt = '0;
                end
            end
            COPY: begin
                if (req) pending_nxt = 1'b1;
                if (dma_cen) begin
                    rd_issue    = 1'b1;
                    wr_en       = (rd_addr != '0);
                    rd_addr_nxt = rd_addr + 1'b1;
                    if (rd_addr == '1) state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (req) pending_nxt = 1'b1;
                if (dma_cen) begin
                    wr_en     = 1'b1;
                    state_nxt = SWAP;
                end
            end
            SWAP: begin
                swap = 1'b1;
                if (pending || req) begin
                    // a request landing in SWAP itself still queues behind the restarted copy
                    state_nxt   = COPY;
                    rd_addr_nxt = '0;
                    pending_nxt = pending & req;
                end else begin
                    state_nxt   = IDLE;
                    pending_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sequencer state, request edge detector and bank pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_addr     <= '0;
            pending     <= 1'b0;
            obj_copy_q  <= 1'b0;
            armed       <= 1'b0;
            active_bank <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_addr    <= rd_addr_nxt;
            pending    <= pending_nxt;
            obj_copy_q <= obj_copy;
            armed      <= 1'b1;
            if (swap) active_bank <= ~active_bank;
        end
    end

    // Staging RAM CPU port: byte-strobed write, registered read-before-write
    always_ff @(posedge clk) begin
        if (objram_cs && !cpu_rnw) begin
            for (int i = 0; i < BL; i++) begin
                if (!cpu_dsn[i]) stg_mem[cpu_addr][i*8 +: 8] <= cpu_dout[i*8 +: 8];
            end
        end
        obj_dout <= stg_mem[cpu_addr];
    end

    // Staging RAM DMA port: holds its data across stalled cycles
    always_ff @(posedge clk) begin
        if (rd_issue) stg_rd_dat <= stg_mem[rd_addr];
    end

    // Display RAM: DMA writes the hidden bank, video reads the shown bank
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (active_bank) bank0[wr_addr] <= stg_rd_dat;
            else             bank1[wr_addr] <= stg_rd_dat;
        end
        vid_data <= active_bank ? bank1[vid_addr] : bank0[vid_addr];
    end

endmodule

// File: tb/tb_jtcop_obj_dma.sv
module tb_jtcop_obj_dma;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_dout;
    logic [1:0]    cpu_dsn;
    logic          cpu_rnw;
    logic          objram_cs;
    logic [DW-1:0] obj_dout;
    logic          obj_copy;
    logic          dma_cen;
    logic          dma_busy;
    logic          dma_done;
    logic          active_bank;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;

    jtcop_obj_dma #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_dsn(cpu_dsn),
        .cpu_rnw(cpu_rnw), .objram_cs(objram_cs), .obj_dout(obj_dout),
        .obj_copy(obj_copy), .dma_cen(dma_cen), .dma_busy(dma_busy),
        .dma_done(dma_done), .active_bank(active_bank),
        .vid_addr(vid_addr), .vid_data(vid_data)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int busy_tot = 0;
    int done_tot = 0;
    bit tog = 1'b0;

    // reference model: staging contents, both display banks, shown bank
    logic [DW-1:0] stg_m  [DEPTH];
    logic [DW-1:0] bank_m [2][DEPTH];
    logic [DW-1:0] snap   [DEPTH];
    logic          ab_m;

    int b0, d0;
    logic [DW-1:0] rv;

    // cycle counters for busy and done, sampled mid-cycle
    always @(negedge clk) begin
        if (dma_busy === 1'b1) busy_tot <= busy_tot + 1;
        if (dma_done === 1'b1) done_tot <= done_tot + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (tog) dma_cen = ~dma_cen;
    endtask

    task automatic cpu_wr(input int a, input logic [DW-1:0] d, input logic [1:0] dsn);
        cpu_addr  = AW'(a);
        cpu_dout  = d;
        cpu_dsn   = dsn;
        cpu_rnw   = 1'b0;
        objram_cs = 1'b1;
        cyc();
        objram_cs = 1'b0;
        cpu_rnw   = 1'b1;
        cpu_dsn   = 2'b11;
        for (int i = 0; i < 2; i++)
            if (!dsn[i]) stg_m[a][i*8 +: 8] = d[i*8 +: 8];
    endtask

    task automatic cpu_rd_chk(input int a, input string tag);
        cpu_addr  = AW'(a);
        cpu_rnw   = 1'b1;
        objram_cs = 1'b1;
        cyc();
        chk(tag, obj_dout, stg_m[a]);
        objram_cs = 1'b0;
    endtask

    task automatic vid_chk_all(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            vid_addr = AW'(a);
            cyc();
            chk(tag, vid_data, bank_m[ab_m][a]);
        end
    endtask

    task automatic start_copy();
        obj_copy = 1'b1;
        cyc();
        obj_copy = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (dma_busy === 1'b0) ok = 1'b1;
            else cyc();
        end
        chk(tag, ok, 1);
    endtask

    // a finished copy moves the staging image to the hidden bank and shows it
    task automatic model_copy_of(input logic [DW-1:0] img [DEPTH]);
        for (int a = 0; a < DEPTH; a++) bank_m[~ab_m][a] = img[a];
        ab_m = ~ab_m;
    endtask

    initial begin
        rst_n = 1'b0; obj_copy = 1'b0; dma_cen = 1'b1;
        cpu_addr = '0; cpu_dout = '0; cpu_dsn = 2'b11; cpu_rnw = 1'b1; objram_cs = 1'b0;
        vid_addr = '0;
        ab_m = 1'b0;
        cyc();
        chk("rst_busy", dma_busy, 0);
        chk("rst_done", dma_done, 0);
        chk("rst_bank", active_bank, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // staging fill and readback
        for (int n = 0; n < DEPTH; n++) cpu_wr(n, DW'(16'hA000 + n), 2'b00);
        for (int n = 0; n < DEPTH; n++) cpu_rd_chk(n, "fill_rd");

        // plain copy at full rate
        b0 = busy_tot; d0 = done_tot;
        for (int a = 0; a < DEPTH; a++) snap[a] = stg_m[a];
        start_copy();
        wait_idle("copy1_timeout");
        cyc();
        chk("copy1_busy_cycles", busy_tot - b0, DEPTH + 2);
        chk("copy1_done_pulses", done_tot - d0, 1);
        chk("copy1_bank", active_bank, 1);
        model_copy_of(snap);
        vid_addr = 4'd5;
        cyc();
        chk("copy1_vid5", vid_data, 16'hA005);
        vid_chk_all("copy1_vid");

        // copy paced by dma_cen toggling 1,0 from the first copy cycle
        b0 = busy_tot; d0 = done_tot;
        tog = 1'b1; dma_cen = 1'b0;
        start_copy();
        wait_idle("copy2_timeout");
        tog = 1'b0; dma_cen = 1'b1;
        cyc();
        chk("copy2_busy_cycles", busy_tot - b0, 2 * DEPTH + 2);
        chk("copy2_done_pulses", done_tot - d0, 1);
        chk("copy2_bank", active_bank, 0);
        model_copy_of(snap);
        vid_chk_all("copy2_vid");

        // byte strobes
        cpu_wr(3, 16'hFFFF, 2'b00);
        cpu_wr(3, 16'h1234, 2'b01);
        cpu_addr = 4'd3; objram_cs = 1'b1;
        cyc();
        objram_cs = 1'b0;
        chk("strobe_hi_only", obj_dout, 16'h12FF);
        for (int k = 0; k < 24; k++)
            cpu_wr($urandom_range(0, DEPTH - 1), DW'($urandom), 2'($urandom));
        for (int n = 0; n < DEPTH; n++) cpu_rd_chk(n, "rand_rd");

        // two further requests during one copy merge into a single back-to-back copy
        b0 = busy_tot; d0 = done_tot;
        for (int a = 0; a < DEPTH; a++) snap[a] = stg_m[a];
        start_copy();
        repeat (3) cyc();
        start_copy();
        repeat (2) cyc();
        start_copy();
        wait_idle("pend_timeout");
        cyc();
        chk("pend_busy_cycles", busy_tot - b0, 2 * (DEPTH + 2));
        chk("pend_done_pulses", done_tot - d0, 2);
        chk("pend_bank", active_bank, 0);
        model_copy_of(snap);
        model_copy_of(snap);
        vid_chk_all("pend_vid");

        // CPU writes during a copy: addr 0 already read (old value copied), addr 15 not yet read
        cpu_wr(0, 16'h0F0F, 2'b00);
        for (int a = 0; a < DEPTH; a++) snap[a] = stg_m[a];
        start_copy();
        repeat (2) cyc();
        cpu_wr(0, 16'h5555, 2'b00);
        rv = DW'($urandom);
        cpu_wr(15, rv, 2'b00);
        snap[15] = rv;
        wait_idle("midwr_timeout");
        model_copy_of(snap);
        vid_addr = 4'd0;
        cyc();
        chk("midwr_vid0_old", vid_data, 16'h0F0F);
        vid_chk_all("midwr_vid");
        cpu_rd_chk(0, "midwr_stg0");

        // reset in the middle of a copy, with obj_copy held high across release
        start_copy();
        repeat (7) cyc();
        d0 = done_tot;
        rst_n = 1'b0;
        obj_copy = 1'b1;
        #1;
        chk("midrst_busy", dma_busy, 0);
        chk("midrst_done", dma_done, 0);
        chk("midrst_bank", active_bank, 0);
        ab_m = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (4) cyc();
        chk("held_high_no_trig", dma_busy, 0);
        chk("midrst_no_done", done_tot - d0, 0);
        obj_copy = 1'b0;
        cyc();
        for (int k = 0; k < 6; k++)
            cpu_wr($urandom_range(0, DEPTH - 1), DW'($urandom), 2'b00);
        b0 = busy_tot; d0 = done_tot;
        for (int a = 0; a < DEPTH; a++) snap[a] = stg_m[a];
        start_copy();
        wait_idle("after_rst_timeout");
        cyc();
        chk("after_rst_busy_cycles", busy_tot - b0, DEPTH + 2);
        chk("after_rst_done", done_tot - d0, 1);
        chk("after_rst_bank", active_bank, 1);
        model_copy_of(snap);
        vid_chk_all("after_rst_vid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
